// File: rtl/chess_clock_pkg.sv
// Shared state encoding, BCD digit limits and PRESET sanitising for the chess clock bank.
// Pure declarations; no logic of its own.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLAGGED = 2'd2
  } state_e;

  localparam logic [3:0]  UNITS_MAX    = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [15:0] SAT_TIME     = 16'h9959;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [15:0] clamp_preset(input logic [15:0] p);
    return {clamp_digit(p[15:12], UNITS_MAX), clamp_digit(p[11:8], UNITS_MAX),
            clamp_digit(p[7:4], SEC_TENS_MAX), clamp_digit(p[3:0], UNITS_MAX)};
  endfunction

endpackage

// File: rtl/bcd_mmss_step.sv
// One-second BCD mm:ss step (up or down) followed by a saturating bonus-second add.
// Purely combinational, 0-cycle latency.
module bcd_mmss_step
  import chess_clock_pkg::*;
(
  input  logic [15:0] time_i,
  input  logic        tick_i,
  input  logic        up_i,
  input  logic [15:0] limit_i,
  input  logic [5:0]  add_sec_i,
  output logic [15:0] ticked_o,
  output logic        term_o,
  output logic [15:0] bumped_o
);

  logic [3:0]  mt, mu, st, su;
  logic [12:0] secs, sum;
  logic [6:0]  mins;
  logic [5:0]  rem;

  always_comb begin
    {mt, mu, st, su} = time_i;
    if (tick_i && up_i && (time_i != SAT_TIME)) begin
      if (su < UNITS_MAX) su = su + 4'd1;
      else begin
        su = 4'd0;
        if (st < SEC_TENS_MAX) st = st + 4'd1;
        else begin
          st = 4'd0;
          if (mu < UNITS_MAX) mu = mu + 4'd1;
          else begin
            mu = 4'd0;
            mt = mt + 4'd1;
          end
        end
      end
    end else if (tick_i && !up_i && (time_i != 16'h0000)) begin
      if (su != 4'd0) su = su - 4'd1;
      else begin
        su = UNITS_MAX;
        if (st != 4'd0) st = st - 4'd1;
        else begin
          st = SEC_TENS_MAX;
          if (mu != 4'd0) mu = mu - 4'd1;
          else begin
            mu = UNITS_MAX;
            mt = mt - 4'd1;
          end
        end
      end
    end
    ticked_o = {mt, mu, st, su};
    term_o   = up_i ? (ticked_o == limit_i) : (ticked_o == 16'h0000);

    // Bonus is added in binary seconds so the saturation test is a single compare.
    secs = 13'(mt) * 13'd600 + 13'(mu) * 13'd60 + 13'(st) * 13'd10 + 13'(su);
    sum  = secs + 13'(add_sec_i);
    mins = 7'(sum / 13'd60);
    rem  = 6'(sum % 13'd60);
    if (sum > 13'd5999) bumped_o = SAT_TIME;
    else bumped_o = {4'(mins / 7'd10), 4'(mins % 7'd10), 4'(rem / 6'd10), 4'(rem % 6'd10)};
  end

endmodule

// File: rtl/chess_clock_bank.sv
// Multi-player BCD chess clock: runs the active player's timer on IMPULSE, flags time-out.
// State, ACTIVE and FLAG update on one edge; display outputs are a 0-cycle mux of the timers.
module chess_clock_bank
  import chess_clock_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int COUNT_DOWN = 1,
  parameter int INC_SEC    = 0
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic                         CE,
  input  logic                         IMPULSE,
  input  logic                         LOAD,
  input  logic [15:0]                  PRESET,
  input  logic                         START,
  input  logic                         SWITCH,
  input  logic [$clog2(N_PLAYERS)-1:0] DISP_SEL,
  output logic [3:0]                   min_tens,
  output logic [3:0]                   min_units,
  output logic [3:0]                   sec_tens,
  output logic [3:0]                   sec_units,
  output logic [$clog2(N_PLAYERS)-1:0] ACTIVE,
  output logic                         RUNNING,
  output logic [N_PLAYERS-1:0]         FLAG
);

  localparam int         AW      = $clog2(N_PLAYERS);
  localparam logic [5:0] ADD_SEC = (COUNT_DOWN != 0) ? 6'(INC_SEC) : 6'd0;

  state_e               state_q, state_d;
  logic [15:0]          timer_q [N_PLAYERS];
  logic [15:0]          limit_q;
  logic [AW-1:0]        active_q;
  logic [N_PLAYERS-1:0] flag_q;

  logic [15:0] cur_time, ticked, bumped, disp_time;
  logic        tick, term, switch_ok, flag_now;

  assign cur_time = timer_q[active_q];
  assign tick     = (state_q == ST_RUN) && IMPULSE && CE;
  // A tick that lands on the terminal value swallows a same-cycle SWITCH.
  assign switch_ok = (state_q == ST_RUN) && SWITCH && !(tick && term);
  assign flag_now  = ((state_q == ST_RUN) && tick && term) ||
                     ((state_q == ST_IDLE) && START && term);

  bcd_mmss_step u_step (
    .time_i   (cur_time),
    .tick_i   (tick),
    .up_i     (COUNT_DOWN == 0),
    .limit_i  (limit_q),
    .add_sec_i(ADD_SEC),
    .ticked_o (ticked),
    .term_o   (term),
    .bumped_o (bumped)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (LOAD) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:    if (START) state_d = term ? ST_FLAGGED : ST_RUN;
        ST_RUN:     if (tick && term) state_d = ST_FLAGGED;
        ST_FLAGGED: state_d = ST_FLAGGED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    RUNNING   = (state_q == ST_RUN);
    disp_time = 16'h0000;
    if (int'(DISP_SEL) < N_PLAYERS) disp_time = timer_q[DISP_SEL];
  end

  assign {min_tens, min_units, sec_tens, sec_units} = disp_time;
  assign ACTIVE = active_q;
  assign FLAG   = flag_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < N_PLAYERS; i++) timer_q[i] <= 16'h0000;
      limit_q  <= 16'h0000;
      active_q <= '0;
      flag_q   <= '0;
    end else if (LOAD) begin
      for (int i = 0; i < N_PLAYERS; i++)
        timer_q[i] <= (COUNT_DOWN != 0) ? clamp_preset(PRESET) : 16'h0000;
      limit_q  <= clamp_preset(PRESET);
      active_q <= '0;
      flag_q   <= '0;
    end else begin
      if (tick || switch_ok) timer_q[active_q] <= switch_ok ? bumped : ticked;
      if (switch_ok)
        active_q <= (active_q == AW'(N_PLAYERS - 1)) ? '0 : active_q + AW'(1);
      if (flag_now) flag_q[active_q] <= 1'b1;
    end
  end

endmodule
